multicycle_ctrl_unit: RTL and testbench

Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and write-back, and drives the datapath selects and enables from the latched instruction fields. Instruction and data memory accesses use req/ready handshakes with a watchdog timeout. A retired-instruction counter is provided, and the FSM halts in a trap state on an illegal opcode or a bus timeout.

---
 rtl/multicycle_ctrl_unit.sv | 132 +++++++++++++
 tb/tb_multicycle_ctrl_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: RV32I multi-cycle control FSM with handshake watchdog and retire counter
module multicycle_ctrl_unit #(
    parameter int WIDTH    = 32,
    parameter int ALU_OP_W = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                branch_taken,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                DM_write_en,
    output logic                ir_write_en,
    output logic                pc_write_en,
    output logic                PC_MUX_sel,
    output logic                port_A_sel,
    output logic                port_B_sel,
    output logic [2:0]          imm_sel,
    output logic [1:0]          write_MUX_sel,
    output logic                reg_write_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal_instr,
    output logic                bus_error,
    output logic [2:0]          state,
    output logic [WIDTH-1:0]    instret
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_JALR, C_S, C_B, C_AUIPC, C_LUI, C_JAL, C_FENCE, C_BAD} cls_t;
    localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    state_t          st, st_n;
    cls_t            cls, dec;
    logic [WD_W-1:0] wd;
    logic            waiting, tmo;

    assign state = st;

    always_comb begin
        dec = C_BAD;
        case (opcode)
            7'b0110011: dec = C_R;
            7'b0010011: dec = C_I;
            7'b0000011: dec = C_LOAD;
            7'b1100111: dec = C_JALR;
            7'b0100011: dec = C_S;
            7'b1100011: dec = C_B;
            7'b0010111: dec = C_AUIPC;
            7'b0110111: dec = C_LUI;
            7'b1101111: dec = C_JAL;
            7'b0001111: dec = C_FENCE;
            default:    dec = C_BAD;
        endcase
    end

    // Ready takes priority: a timeout fires only on a cycle still without ready
    assign waiting = (st == FETCH && !imem_ready) || (st == MEM && !dmem_ready);
    assign tmo     = TIMEOUT != 0 && waiting && wd == WD_W'(TIMEOUT - 1);

    always_comb begin
        st_n          = st;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        DM_write_en   = 1'b0;
        ir_write_en   = 1'b0;
        pc_write_en   = 1'b0;
        PC_MUX_sel    = 1'b0;
        port_A_sel    = 1'b0;
        port_B_sel    = 1'b0;
        imm_sel       = 3'd0;
        write_MUX_sel = 2'd0;
        reg_write_en  = 1'b0;
        alu_op        = '0;
        case (st)
            FETCH: begin
                imem_req    = 1'b1;
                ir_write_en = imem_ready && !rst;
                st_n        = imem_ready ? DECODE : tmo ? TRAP : FETCH;
            end
            DECODE: st_n = dec == C_BAD ? TRAP : EXEC;
            EXEC: begin
                port_A_sel  = cls inside {C_B, C_AUIPC, C_JAL};
                port_B_sel  = !(cls inside {C_R, C_FENCE});
                imm_sel     = cls == C_S ? 3'd1 : cls == C_B ? 3'd2 :
                              cls inside {C_AUIPC, C_LUI} ? 3'd3 : cls == C_JAL ? 3'd4 : 3'd0;
                alu_op      = cls == C_R ? ALU_OP_W'({funct7_5, funct3}) :
                              cls == C_I ? ALU_OP_W'({funct7_5 && funct3 == 3'b101, funct3}) :
                              cls == C_LUI ? '1 : '0;
                pc_write_en = cls == C_B;
                PC_MUX_sel  = cls == C_B && branch_taken;
                st_n        = cls == C_B ? FETCH : cls inside {C_LOAD, C_S} ? MEM : WB;
            end
            MEM: begin
                dmem_req    = 1'b1;
                DM_write_en = cls == C_S;
                pc_write_en = dmem_ready && cls == C_S;
                st_n        = dmem_ready ? (cls == C_S ? FETCH : WB) : tmo ? TRAP : MEM;
            end
            WB: begin
                pc_write_en   = 1'b1;
                reg_write_en  = cls != C_FENCE;
                write_MUX_sel = cls == C_LOAD ? 2'd1 : cls inside {C_JAL, C_JALR} ? 2'd2 : 2'd0;
                PC_MUX_sel    = cls inside {C_JAL, C_JALR};
                st_n          = FETCH;
            end
            TRAP:    st_n = TRAP;
            default: st_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= FETCH;
            cls           <= C_R;
            wd            <= '0;
            instret       <= '0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            st <= st_n;
            wd <= waiting ? wd + WD_W'(1) : '0;
            if (st == DECODE) cls <= dec;
            if (pc_write_en) instret <= instret + WIDTH'(1);
            if (st == DECODE && dec == C_BAD) illegal_instr <= 1'b1;
            if (tmo) bus_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb_multicycle_ctrl_unit: directed checks of the control FSM (WIDTH=4, TIMEOUT=4)
module tb_multicycle_ctrl_unit;
    logic       clk, rst, funct7_5, branch_taken, imem_ready, dmem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       imem_req, dmem_req, DM_write_en, ir_write_en, pc_write_en, PC_MUX_sel;
    logic       port_A_sel, port_B_sel, reg_write_en, illegal_instr, bus_error;
    logic [2:0] imm_sel, state;
    logic [1:0] write_MUX_sel;
    logic [3:0] alu_op, instret;
    int         n_vec = 0, n_err = 0;

    multicycle_ctrl_unit #(.WIDTH(4), .ALU_OP_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .DM_write_en(DM_write_en),
        .ir_write_en(ir_write_en), .pc_write_en(pc_write_en), .PC_MUX_sel(PC_MUX_sel),
        .port_A_sel(port_A_sel), .port_B_sel(port_B_sel), .imm_sel(imm_sel),
        .write_MUX_sel(write_MUX_sel), .reg_write_en(reg_write_en), .alu_op(alu_op),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .state(state), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [31:0] ir);
        opcode   = ir[6:0];
        funct3   = ir[14:12];
        funct7_5 = ir[30];
    endtask

    // Leaves the FSM in DECODE with the instruction fields applied
    task automatic fetch(input string tag, input logic [31:0] ir);
        set_ir(ir);
        imem_ready = 1'b1;
        #1;
        chk({tag, "_fetch"}, {state, imem_req, ir_write_en}, {3'd0, 1'b1, 1'b1});
        step;
        imem_ready = 1'b0;
        #1;
        chk({tag, "_dec"}, {state, ir_write_en}, {3'd1, 1'b0});
        step;
    endtask

    task automatic run_wb(input string tag, input logic [31:0] ir, input logic [3:0] e_alu,
                          input logic e_a, input logic e_b, input logic [2:0] e_imm,
                          input logic [1:0] e_wm, input logic e_pcm, input logic e_rw);
        fetch(tag, ir);
        chk({tag, "_exec"}, {state, alu_op, port_A_sel, port_B_sel, imm_sel, pc_write_en, reg_write_en},
            {3'd2, e_alu, e_a, e_b, e_imm, 1'b0, 1'b0});
        step;
        chk({tag, "_wb"}, {state, pc_write_en, reg_write_en, write_MUX_sel, PC_MUX_sel, alu_op},
            {3'd4, 1'b1, e_rw, e_wm, e_pcm, 4'd0});
        step;
        chk({tag, "_done"}, {29'd0, state}, 32'd0);
    endtask

    task automatic run_b(input string tag, input logic taken);
        fetch(tag, 32'h00208463);
        branch_taken = taken;
        #1;
        chk({tag, "_exec"}, {state, pc_write_en, PC_MUX_sel, port_A_sel, port_B_sel, imm_sel, reg_write_en, alu_op},
            {3'd2, 1'b1, taken, 1'b1, 1'b1, 3'd2, 1'b0, 4'd0});
        step;
        branch_taken = 1'b0;
        chk({tag, "_done"}, {state, reg_write_en}, {3'd0, 1'b0});
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b0;
        set_ir(32'h0);
        #2;
        chk("rst_state", {state, imem_req, illegal_instr, bus_error, instret}, {3'd0, 1'b1, 1'b0, 1'b0, 4'd0});
        chk("rst_zero", {ir_write_en, dmem_req, DM_write_en, pc_write_en, PC_MUX_sel, port_A_sel,
                         port_B_sel, imm_sel, write_MUX_sel, reg_write_en, alu_op}, 32'd0);
        imem_ready = 1'b0;
        step; step;
        rst = 1'b0;

        run_wb("add", 32'h002081B3, 4'h0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
        chk("add_instret", {28'd0, instret}, 32'd1);

        // LW with dmem_ready arriving on the 4th request cycle (watchdog boundary)
        fetch("lw", 32'h0000A103);
        chk("lw_exec", {state, alu_op, port_B_sel, imm_sel}, {3'd2, 4'd0, 1'b1, 3'd0});
        step;
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait", {state, dmem_req, DM_write_en, pc_write_en}, {3'd3, 1'b1, 1'b0, 1'b0});
            step;
        end
        dmem_ready = 1'b1;
        #1;
        chk("lw_ready", {state, dmem_req, DM_write_en, pc_write_en}, {3'd3, 1'b1, 1'b0, 1'b0});
        step;
        dmem_ready = 1'b0;
        chk("lw_wb", {state, write_MUX_sel, reg_write_en, pc_write_en, dmem_req}, {3'd4, 2'd1, 1'b1, 1'b1, 1'b0});
        step;
        chk("lw_done", {state, bus_error, instret}, {3'd0, 1'b0, 4'd2});

        run_b("beq_t", 1'b1);
        run_b("beq_nt", 1'b0);
        chk("beq_instret", {28'd0, instret}, 32'd4);

        run_wb("jal", 32'h008000EF, 4'h0, 1'b1, 1'b1, 3'd4, 2'd2, 1'b1, 1'b1);
        run_wb("sub", 32'h40208233, 4'h8, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
        run_wb("srai", 32'h4010D093, 4'hD, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1);
        run_wb("addi", 32'h40008093, 4'h0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1);
        run_wb("lui", 32'h000010B7, 4'hF, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0, 1'b1);

        fetch("sw", 32'h0020A023);
        chk("sw_exec", {state, alu_op, port_A_sel, port_B_sel, imm_sel}, {3'd2, 4'd0, 1'b0, 1'b1, 3'd1});
        step;
        dmem_ready = 1'b1;
        #1;
        chk("sw_mem", {state, dmem_req, DM_write_en, pc_write_en, PC_MUX_sel, reg_write_en},
            {3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        step;
        dmem_ready = 1'b0;
        chk("sw_done", {28'd0, state, 1'b0}, 32'd0);

        run_wb("fence", 32'h0000000F, 4'h0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        chk("mix_instret", {28'd0, instret}, 32'd11);

        for (int i = 0; i < 4; i++) run_b("fill", 1'b0);
        chk("pre_wrap", {28'd0, instret}, 32'd15);
        run_b("wrap", 1'b1);
        chk("wrap_instret", {28'd0, instret}, 32'd0);

        // Fetch watchdog: 4 cycles without imem_ready, then TRAP
        imem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait", {state, imem_req, bus_error}, {3'd0, 1'b1, 1'b0});
            step;
        end
        chk("to_trap", {state, bus_error, imem_req, illegal_instr}, {3'd5, 1'b1, 1'b0, 1'b0});
        imem_ready = 1'b1;
        step;
        chk("to_hold", {state, bus_error, imem_req, ir_write_en}, {3'd5, 1'b1, 1'b0, 1'b0});
        imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("to_rst", {state, bus_error, imem_req, instret}, {3'd0, 1'b0, 1'b1, 4'd0});
        step;
        rst = 1'b0;

        fetch("ecall", 32'h00000073);
        chk("ill_trap", {state, illegal_instr, imem_req, bus_error}, {3'd5, 1'b1, 1'b0, 1'b0});
        step; step;
        chk("ill_hold", {state, illegal_instr, imem_req, pc_write_en, instret}, {3'd5, 1'b1, 1'b0, 1'b0, 4'd0});
        rst = 1'b1;
        #1;
        chk("ill_rst", {state, illegal_instr, bus_error, imem_req, instret}, {3'd0, 1'b0, 1'b0, 1'b1, 4'd0});
        step;
        rst = 1'b0;

        fetch("abort", 32'h0000A103);
        step;
        chk("abort_mem", {state, dmem_req}, {3'd3, 1'b1});
        rst = 1'b1;
        #1;
        chk("abort_rst", {state, dmem_req, pc_write_en, instret}, {3'd0, 1'b0, 1'b0, 4'd0});
        step;
        rst = 1'b0;
        run_wb("add2", 32'h002081B3, 4'h0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
        chk("add2_instret", {28'd0, instret}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
